// File: rtl/mux_sel_feeder_pkg.sv
// Shared types, widths and scan-edge helpers for the mux select feeder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Optional build macro: MUX_SEL_FEEDER_REVERSE_EN selects an MSB-first
// (descending) scan. When it is undefined the scan runs LSB-first.
package mux_sel_feeder_pkg;

  // Select code width for the 8:1 mux (S is 4 bits, bit = D[S>>1]).
  localparam int SEL_W  = 4;
  // Width of the mux data bus D.
  localparam int DATA_W = 8;
  // Number of distinct select codes.
  localparam int SEL_CODES = 1 << SEL_W;

`ifdef MUX_SEL_FEEDER_REVERSE_EN
  // Descending scan: start at the high edge, finish at code 0.
  localparam bit REVERSE = 1'b1;
`else
  // Ascending scan: start at code 0, finish at the high edge.
  localparam bit REVERSE = 1'b0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Low edge of the scan is always code 0; the high edge is the last code
  // reachable from 0 in whole steps (14 for STEP=2, 15 for STEP=1).
  function automatic logic [SEL_W-1:0] scan_edge(input int step, input bit hi);
    return hi ? SEL_W'(SEL_CODES - step) : '0;
  endfunction

  // First select code of a word.
  function automatic logic [SEL_W-1:0] scan_start(input int step);
    return scan_edge(step, REVERSE);
  endfunction

  // Last select code of a word.
  function automatic logic [SEL_W-1:0] scan_end(input int step);
    return scan_edge(step, !REVERSE);
  endfunction

endpackage

// File: rtl/mux_sel_idx.sv
// Select counter: loads the scan start code, advances by STEP per beat.
// Latency: one cycle from i_load / i_adv to the new o_sel value.
// Backpressure: holds o_sel whenever neither i_load nor i_adv is asserted.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset (reset -> START)
//   i_load        load the scan start code (takes priority over i_adv)
//   i_adv         step o_sel one beat towards the scan end
//   o_sel         current select code
//   o_is_first    o_sel equals the scan start code
//   o_is_last     o_sel equals the scan end code
//
// Scan direction follows MUX_SEL_FEEDER_REVERSE_EN through the package.
module mux_sel_idx
  import mux_sel_feeder_pkg::*;
#(
  parameter int STEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_adv,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_is_first,
  output logic             o_is_last
);

  // Only 1 and 2 divide the 16-code space into a scan that visits each
  // data bit the same number of times.
  if (STEP != 1 && STEP != 2) begin : g_bad_step
    $error("mux_sel_idx: STEP must be 1 or 2");
  end

  localparam logic [SEL_W-1:0] START  = scan_start(STEP);
  localparam logic [SEL_W-1:0] END    = scan_end(STEP);
  localparam logic [SEL_W-1:0] STEP_V = SEL_W'(STEP);

  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_next;

  // The scan never crosses the edges inside a word, so plain 4-bit
  // arithmetic is enough; the owner reloads START before any wrap.
  always_comb begin
    w_sel_next = r_sel;
    if (i_load) begin
      w_sel_next = START;
    end else if (i_adv) begin
      w_sel_next = REVERSE ? (r_sel - STEP_V) : (r_sel + STEP_V);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= START;
    end else begin
      r_sel <= w_sel_next;
    end
  end

  assign o_sel      = r_sel;
  assign o_is_first = (r_sel == START);
  assign o_is_last  = (r_sel == END);

endmodule

// File: rtl/mux_sel_feeder.sv
// Feeds an 8:1 data-select mux: holds a word on D and scans S across it.
// Latency: first beat one cycle after accept; back-to-back words, no bubble.
// Backpressure: beat (d_out, s_out) holds while sel_valid && !sel_ready.
//
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   in_valid/in_ready     upstream word handshake (in_ready is combinational)
//   in_data               word to serialise
//   d_out                 mux data bus, constant for every beat of a word
//   s_out                 mux select code
//   sel_valid/sel_ready   downstream beat handshake
//   sel_first/sel_last    beat is the first / last of the current word
//   words_done            count of fully transferred words, wraps silently
//
// Build macro MUX_SEL_FEEDER_REVERSE_EN (via the package) makes the scan
// run MSB-first; handshake, counter and stall behaviour are unchanged.
module mux_sel_feeder
  import mux_sel_feeder_pkg::*;
#(
  parameter int STEP = 2,
  parameter int CW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] d_out,
  output logic [SEL_W-1:0]  s_out,
  output logic              sel_valid,
  input  logic              sel_ready,
  output logic              sel_first,
  output logic              sel_last,
  output logic [CW-1:0]     words_done
);

  state_t            r_state;
  logic [DATA_W-1:0] r_d_out;
  logic              r_sel_valid;
  logic [CW-1:0]     r_words_done;

  logic              w_xfer;
  logic              w_word_end;
  logic              w_idx_load;
  logic              w_idx_adv;
  logic              w_is_first;
  logic              w_is_last;
  logic [SEL_W-1:0]  w_sel;

  // A beat moves when both sides agree; the word ends on the last beat.
  assign w_xfer     = r_sel_valid && sel_ready;
  assign w_word_end = w_xfer && w_is_last;

  // A new word can be taken while idle, or in the very cycle the previous
  // word's last beat leaves, which is what removes the bubble.
  assign in_ready = (r_state == IDLE) || w_word_end;

  // Loading START while idle is harmless (the counter already sits there)
  // and keeps the load term identical to the accept window.
  assign w_idx_load = (r_state == IDLE) || w_word_end;
  assign w_idx_adv  = w_xfer && !w_is_last;

  mux_sel_idx #(
    .STEP (STEP)
  ) u_idx (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_idx_load),
    .i_adv      (w_idx_adv),
    .o_sel      (w_sel),
    .o_is_first (w_is_first),
    .o_is_last  (w_is_last)
  );

  // Handshake FSM. d_out is only written on accept, so it stays fixed for
  // every beat of a word and keeps the last word while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_d_out      <= '0;
      r_sel_valid  <= 1'b0;
      r_words_done <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_d_out     <= in_data;
            r_sel_valid <= 1'b1;
            r_state     <= SCAN;
          end
        end
        SCAN: begin
          if (w_word_end) begin
            r_words_done <= r_words_done + 1'b1;
            if (in_valid) begin
              // Next word starts straight away; sel_valid stays high.
              r_d_out <= in_data;
            end else begin
              r_sel_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_sel_valid <= 1'b0;
        end
      endcase
    end
  end

  assign d_out      = r_d_out;
  assign s_out      = w_sel;
  assign sel_valid  = r_sel_valid;
  assign sel_first  = r_sel_valid && w_is_first;
  assign sel_last   = r_sel_valid && w_is_last;
  assign words_done = r_words_done;

  // A stalled beat must present the same select and data next cycle.
  a_stall_hold: assert property (@(posedge clk) disable iff (rst)
    (r_sel_valid && !sel_ready) |=> (r_sel_valid && $stable(s_out) && $stable(d_out)));

  // Within a word the data bus never changes.
  a_word_hold: assert property (@(posedge clk) disable iff (rst)
    (w_xfer && !w_is_last) |=> $stable(d_out));

  // sel_valid is high exactly while scanning.
  a_state_vld: assert property (@(posedge clk) disable iff (rst)
    ((r_state == SCAN) == r_sel_valid));

endmodule

// File: tb/tb_mux_sel_feeder.sv
module tb_mux_sel_feeder;

`ifdef MUX_SEL_FEEDER_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       sel_ready;

  // Instance 0: STEP=2, CW=8. Instance 1: STEP=1, CW=4 (wraps quickly).
  logic       rdy0, v0, f0, l0;
  logic [7:0] d0;
  logic [3:0] s0;
  logic [7:0] wd0;
  logic       rdy1, v1, f1, l1;
  logic [7:0] d1;
  logic [3:0] s1;
  logic [3:0] wd1;

  int n_cmp = 0;
  int n_bad = 0;

  mux_sel_feeder #(.STEP(2), .CW(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .d_out(d0), .s_out(s0), .sel_valid(v0), .sel_ready(sel_ready),
    .sel_first(f0), .sel_last(l0), .words_done(wd0)
  );

  mux_sel_feeder #(.STEP(1), .CW(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .d_out(d1), .s_out(s1), .sel_valid(v1), .sel_ready(sel_ready),
    .sel_first(f1), .sel_last(l1), .words_done(wd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each word is a sequence of 16/STEP beats; beat b selects code
  // b*STEP (ascending) or 16-STEP-b*STEP (descending).
  bit m_busy [2];
  int m_word [2];
  int m_beat [2];
  int m_cnt  [2];
  int M_ST   [2] = '{2, 1};
  int M_MASK [2] = '{255, 15};

  function automatic int code_of(input int st, input int b);
    return REV ? (16 - st - b * st) : (b * st);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 1'b0; m_word[k] = 0; m_beat[k] = 0; m_cnt[k] = 0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      int nb;
      string p;
      nb = 16 / M_ST[k];
      p  = (k == 0) ? "u0." : "u1.";
      chk({p, "sel_valid"}, k ? int'(v1) : int'(v0), int'(m_busy[k]));
      chk({p, "d_out"},     k ? int'(d1) : int'(d0), m_word[k]);
      chk({p, "s_out"},     k ? int'(s1) : int'(s0), code_of(M_ST[k], m_beat[k]));
      chk({p, "sel_first"}, k ? int'(f1) : int'(f0), int'(m_busy[k] && m_beat[k] == 0));
      chk({p, "sel_last"},  k ? int'(l1) : int'(l0), int'(m_busy[k] && m_beat[k] == nb - 1));
      chk({p, "words_done"}, k ? int'(wd1) : int'(wd0), m_cnt[k] & M_MASK[k]);
      if (!rst)
        chk({p, "in_ready"}, k ? int'(rdy1) : int'(rdy0),
            int'(!m_busy[k] || (sel_ready && m_beat[k] == nb - 1)));
    end
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        int nb;
        nb = 16 / M_ST[k];
        if (!m_busy[k]) begin
          if (in_valid) begin
            m_busy[k] = 1'b1; m_word[k] = int'(in_data); m_beat[k] = 0;
          end
        end else if (sel_ready) begin
          if (m_beat[k] == nb - 1) begin
            m_cnt[k]++;
            m_beat[k] = 0;
            if (in_valid) m_word[k] = int'(in_data);
            else          m_busy[k] = 1'b0;
          end else begin
            m_beat[k]++;
          end
        end
      end
    end
  end

  // ---------------- stimulus + literal pins ----------------
  bit yexp [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int start_code;
  int t;

  initial begin
    start_code = REV ? 14 : 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; sel_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset in_ready", int'(rdy0), 1);
    chk("reset s_out", int'(s0), start_code);
    chk("reset d_out", int'(d0), 0);

    // Word 0xA5, STEP=2: eight beats, mux output 1,0,1,0,0,1,0,1.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hA5; sel_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("a5 first beat sel_first", int'(f0), 1);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] dv;
      logic [2:0] bi;
      dv = d0;
      bi = s0[3:1];
      chk("a5 mux y", int'(dv[bi]), int'(yexp[i]));
      chk("a5 s_out", int'(s0), REV ? (14 - 2 * i) : (2 * i));
      chk("a5 sel_last", int'(l0), int'(i == 7));
      @(posedge clk); #1;
    end
    chk("a5 words_done", int'(wd0), 1);
    chk("a5 idle sel_valid", int'(v0), 0);
    repeat (8) @(posedge clk);
    #1;
    chk("step1 words_done", int'(wd1), 1);
    chk("step1 idle sel_valid", int'(v1), 0);

    // Back-to-back: 0x01 then 0xFF with in_valid held.
    in_valid = 1'b1; in_data = 8'h01;
    @(posedge clk); #1;
    in_data = 8'hFF;
    t = 0;
    while (!l0 && t < 20) begin @(posedge clk); #1; t++; end
    chk("b2b last beat seen", int'(t < 20), 1);
    @(posedge clk); #1;
    chk("b2b sel_valid", int'(v0), 1);
    chk("b2b s_out", int'(s0), start_code);
    chk("b2b d_out", int'(d0), 8'hFF);
    chk("b2b words_done", int'(wd0), 2);
    in_valid = 1'b0;
    t = 0;
    while ((v0 || v1) && t < 40) begin @(posedge clk); #1; t++; end
    chk("b2b drain", int'(t < 40), 1);

    // Backpressure at s_out=6 for three cycles.
    in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!(v0 && s0 == 4'd6) && t < 20) begin @(posedge clk); #1; t++; end
    chk("bp reach 6", int'(t < 20), 1);
    sel_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp s_out hold", int'(s0), 6);
      chk("bp d_out hold", int'(d0), 8'h5A);
      chk("bp sel_valid hold", int'(v0), 1);
    end
    sel_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp resume", int'(s0), REV ? 4 : 8);
    t = 0;
    while ((v0 || v1) && t < 40) begin @(posedge clk); #1; t++; end
    chk("bp drain", int'(t < 40), 1);

    // Reset mid-word at s_out=10.
    in_valid = 1'b1; in_data = 8'hC3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!(v0 && s0 == 4'd10) && t < 20) begin @(posedge clk); #1; t++; end
    chk("rst reach 10", int'(t < 20), 1);
    rst = 1'b1;
    #2;
    chk("rst sel_valid", int'(v0), 0);
    chk("rst s_out", int'(s0), start_code);
    chk("rst d_out", int'(d0), 0);
    chk("rst words_done", int'(wd0), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 8000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      sel_ready = ($urandom_range(0, 4) != 0);
      rst       = ($urandom_range(0, 2999) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; sel_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
